// File: rtl/demux8_deser.sv
// 1-to-8 bit demultiplexer with an LSB-first scan (serial-to-parallel) mode.
// The mode input sampled on an edge decides how the bit accepted on that edge is routed.
module demux8_deser (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode,
    input  logic       in_valid,
    input  logic       in_bit,
    input  logic [2:0] sel,
    output logic [7:0] out,
    output logic [7:0] out_strobe,
    output logic       byte_valid,
    output logic       busy
);

    typedef enum logic {
        ADDR = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t     state, state_nx;
    logic [2:0] idx, idx_nx;
    logic [2:0] base;
    logic [2:0] wptr;
    logic [7:0] out_nx;
    logic [7:0] strobe_nx;
    logic       bv_nx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ADDR;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = mode ? SCAN : ADDR;
    end

    // A scan entered from ADDR starts at 0 regardless of idx; leaving SCAN clears idx.
    always_comb begin
        base      = (state == SCAN) ? idx : 3'd0;
        wptr      = (state_nx == SCAN) ? base : sel;
        out_nx    = out;
        strobe_nx = '0;
        bv_nx     = 1'b0;
        idx_nx    = (state_nx == SCAN) ? base : 3'd0;
        if (in_valid) begin
            out_nx[wptr] = in_bit;
            strobe_nx    = 8'(1) << wptr;
            if (state_nx == SCAN) begin
                idx_nx = base + 3'd1;
                bv_nx  = (base == 3'd7);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out        <= '0;
            out_strobe <= '0;
            byte_valid <= 1'b0;
            idx        <= '0;
        end else begin
            out        <= out_nx;
            out_strobe <= strobe_nx;
            byte_valid <= bv_nx;
            idx        <= idx_nx;
        end
    end

    always_comb begin
        busy = (state == SCAN) && (idx != 3'd0);
    end

endmodule

// File: tb/tb_demux8_deser.sv
// Directed bench for demux8_deser: a reference model pushes expected outputs to a
// queue on every driven step; they are popped and checked after the clock edge.
module tb_demux8_deser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic [2:0] sel = '0;
    logic [7:0] out;
    logic [7:0] out_strobe;
    logic       byte_valid;
    logic       busy;

    demux8_deser dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .sel       (sel),
        .out       (out),
        .out_strobe(out_strobe),
        .byte_valid(byte_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] o;
        logic [7:0] s;
        logic       bv;
        logic       bz;
    } exp_t;

    exp_t       q[$];
    int         ncmp = 0;
    int         nfail = 0;
    int         bv_cnt = 0;
    logic [7:0] m_out = '0;
    logic [2:0] m_idx = '0;
    logic       m_scan = 1'b0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic r, input logic m, input logic v, input logic b,
                        input logic [2:0] s);
        exp_t       e;
        logic [2:0] p;
        @(negedge clk);
        rst_n = r; mode = m; in_valid = v; in_bit = b; sel = s;
        e.s  = '0;
        e.bv = 1'b0;
        if (!r) begin
            m_out = '0; m_idx = '0; m_scan = 1'b0;
        end else if (m) begin
            p = m_scan ? m_idx : 3'd0;
            m_scan = 1'b1;
            m_idx  = p;
            if (v) begin
                m_out[p] = b;
                e.s      = 8'(1) << p;
                e.bv     = (p == 3'd7);
                m_idx    = p + 3'd1;
            end
        end else begin
            m_scan = 1'b0;
            m_idx  = '0;
            if (v) begin
                m_out[s] = b;
                e.s      = 8'(1) << s;
            end
        end
        e.o  = m_out;
        e.bz = m_scan && (m_idx != 3'd0);
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("out", out, e.o);
        chk("out_strobe", out_strobe, e.s);
        chk("byte_valid", {7'd0, byte_valid}, {7'd0, e.bv});
        chk("busy", {7'd0, busy}, {7'd0, e.bz});
        bv_cnt += int'(byte_valid);
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] strb [4];
        logic [2:0] sels [4];
        sels = '{3'd1, 3'd5, 3'd6, 3'd7};
        strb = '{8'h02, 8'h20, 8'h40, 8'h80};

        // reset, with a bit offered that must be discarded
        step(1'b0, 1'b0, 1'b1, 1'b1, 3'd3);
        chk("rst_out", out, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

        // addressed writes
        for (int unsigned i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b1, sels[i]);
            chk("addr_strobe", out_strobe, strb[i]);
        end
        chk("addr_out", out, 8'hE2);

        // clean scan over a cleared bank
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        pat = 8'hE2;
        bv_cnt = 0;
        for (int unsigned i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, pat[i], 3'd0);
        chk("scan_out", out, 8'hE2);
        chk("scan_bv_cnt", 8'(bv_cnt), 8'd1);
        chk("scan_busy", {7'd0, busy}, 8'd0);

        // scan with alternate idle cycles
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        bv_cnt = 0;
        for (int unsigned i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b1, pat[i], 3'd0);
            step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
            chk("gap_strobe", out_strobe, 8'h00);
        end
        chk("gap_out", out, 8'hE2);
        chk("gap_bv_cnt", 8'(bv_cnt), 8'd1);

        // abort a partial byte, then a full byte of zeros
        bv_cnt = 0;
        for (int unsigned i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
        chk("abort_busy_hi", {7'd0, busy}, 8'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        chk("abort_busy_lo", {7'd0, busy}, 8'd0);
        chk("abort_bv_cnt", 8'(bv_cnt), 8'd0);
        for (int unsigned i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        chk("abort_out", out, 8'h00);
        chk("abort_bv_cnt2", 8'(bv_cnt), 8'd1);

        // reset in the middle of a scan
        bv_cnt = 0;
        for (int unsigned i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 3'd0);
        chk("midrst_out", out, 8'h00);
        chk("midrst_busy", {7'd0, busy}, 8'd0);
        for (int unsigned i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1, 3'd0);
            if (i == 6) chk("midrst_bv_early", 8'(bv_cnt), 8'd0);
        end
        chk("midrst_out_ff", out, 8'hFF);
        chk("midrst_bv_cnt", 8'(bv_cnt), 8'd1);

        // two back-to-back bytes with wrap
        bv_cnt = 0;
        pat = 8'hA5;
        for (int unsigned i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, pat[i], 3'd0);
        chk("wrap_out1", out, 8'hA5);
        pat = 8'h3C;
        for (int unsigned i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, pat[i], 3'd0);
        chk("wrap_out2", out, 8'h3C);
        chk("wrap_bv_cnt", 8'(bv_cnt), 8'd2);

        // mode change coincident with a valid bit uses the new mode
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 3'd5);
        chk("modechg_scan_strobe", out_strobe, 8'h01);
        step(1'b1, 1'b0, 1'b1, 1'b0, 3'd4);
        chk("modechg_addr_strobe", out_strobe, 8'h10);

        // random mix against the model
        for (int unsigned i = 0; i < 200; i++)
            step(($urandom_range(0, 31) != 0), 1'(($urandom_range(0, 9)) > 3),
                 1'($urandom), 1'($urandom), 3'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/demux8_deser.md
DEMUX8_DESER -- requirements
Module: demux8_deser

Interface
REQ-001 The block SHALL have these ports, one per line: name  direction  width  meaning.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- mode  input  1  0 = addressed demux, 1 = scan (serial-to-parallel).
- in_valid  input  1  in_bit is offered and accepted this cycle; there is no backpressure.
- in_bit  input  1  data bit to route.
- sel  input  3  destination index in addressed mode; ignored in scan mode.
- out  output  8  registered, held output bank; bit k is channel k.
- out_strobe  output  8  one-hot, one-cycle pulse marking the channel written in the previous cycle.
- byte_valid  output  1  one-cycle pulse: out holds a complete scanned byte.
- busy  output  1  scan byte partially filled (idx != 0).
REQ-002 The block SHALL have no parameters; all widths are fixed as listed in REQ-001.

Function
REQ-003 The block SHALL keep an internal 3-bit index idx and a state register with states ADDR and SCAN.
REQ-004 State transitions SHALL follow mode each cycle: ADDR->SCAN when mode=1, SCAN->ADDR when mode=0, evaluated on the same edge as data acceptance.
REQ-005 Addressed accept (mode=0, in_valid=1): next edge out[sel]<=in_bit, out_strobe<=one-hot(sel), all other out bits hold; latency 1 cycle.
REQ-006 Scan accept (mode=1, in_valid=1): next edge out[idx]<=in_bit, out_strobe<=one-hot(idx), idx<=idx+1 modulo 8.
REQ-007 In scan mode, when the accepted bit has idx=7, byte_valid SHALL pulse high on the same edge that writes out[7], and idx SHALL wrap to 0.
REQ-008 First scanned bit SHALL land in out[0] (LSB-first deserialization).
REQ-009 in_valid=0: out and idx SHALL hold; out_strobe=0 and byte_valid=0 next cycle.
REQ-010 out_strobe SHALL never have more than one bit set, and SHALL be high only for exactly one cycle per accepted bit.
REQ-011 Leaving SCAN with idx!=0 (mode 1->0): idx SHALL clear to 0 and the partial byte SHALL be dropped (no byte_valid); out bits already written hold.
REQ-012 If mode changes in the same cycle as in_valid=1, the bit SHALL be handled per the new mode value (the mode value sampled on that edge).
REQ-013 Entering SCAN SHALL always start from idx=0.
REQ-014 busy SHALL equal (state==SCAN && idx!=0), registered.
REQ-015 Back-to-back in_valid on consecutive cycles SHALL be accepted at a rate of one bit per clock with no bubbles.

Reset
REQ-016 With rst_n=0 at a rising edge: out=8'h00, out_strobe=8'h00, byte_valid=0, busy=0, idx=0, state=ADDR.
REQ-017 Reset SHALL take priority over in_valid; a bit offered during reset is discarded.
REQ-018 Reset mid-scan SHALL discard the partial byte with no byte_valid; the first scan bit after release SHALL go to out[0].

Verification
REQ-019 Addressed: mode=0, drive in_bit=1 at sel=1,5,6,7 in turn, one per cycle -> out=8'b11100010 after the 4th bit, out_strobe=8'h02,8'h20,8'h40,8'h80 on successive cycles.
REQ-020 Scan: mode=1, 8 consecutive bits 0,1,0,0,0,1,1,1 -> out=8'b11100010, byte_valid pulses once on the 8th write, busy=0 afterwards.
REQ-021 Gaps: scan the same 8 bits with in_valid low on alternate cycles -> identical out=8'hE2, byte_valid exactly once, out_strobe never set in idle cycles.
REQ-022 Abort: mode=1, 3 bits 1,1,1, then mode=0 -> busy falls, no byte_valid; mode=1 again with 8 zeros -> out=8'h00, byte_valid once.
REQ-023 Reset mid-scan: 5 bits 1 scanned, rst_n=0 for 1 cycle -> all outputs zero; 8 bits of 1 -> out=8'hFF, byte_valid after the 8th bit only.
REQ-024 Wrap: 16 scanned bits (8'hA5 then 8'h3C, LSB first) -> byte_valid pulses twice, out=8'hA5 then 8'h3C.
